// File: rtl/riscy_pkg.sv
// Shared RV32I decode constants and the decoded-slot layout used by the
// decode stage and anything downstream that consumes its output.
package riscy_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic        illegal;
        logic [2:0]  funct3;
        logic        funct7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } slot_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two asynchronous read ports and one write port.
// x0 is hardwired to zero; writes to it are dropped.
module regfile #(
    parameter bit REG_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem_q [32];
    logic [31:0] mem_d [32];

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != 5'd0)) begin
            mem_d[waddr] = wdata;
        end
    end

    // A write-back coinciding with reset is discarded even when the array
    // itself is not cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (REG_RESET) begin
                for (int i = 0; i < 32; i++) begin
                    mem_q[i] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : mem_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : mem_q[raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I OP / OP-IMM decode and operand fetch feeding the integer ALU through
// a one-entry registered output slot.
module decode_stage
    import riscy_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit REG_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_funct3,
    output logic            out_funct7,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready depends only on slot occupancy and out_ready.
    slot_state_e state_q, state_d;
    slot_t       slot_q, slot_d;
    slot_t       dec;

    logic [4:0]  rs1_idx, rs2_idx;
    logic [31:0] rf_rd1, rf_rd2, rs1_val, rs2_val, imm;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        legal, accept, wb_live;

    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];
    assign f7      = in_instr[31:25];
    assign f3      = in_instr[14:12];
    assign imm     = {{20{in_instr[31]}}, in_instr[31:20]};

    regfile #(.REG_RESET(REG_RESET)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1_idx),
        .raddr2 (rs2_idx),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    assign wb_live = wb_en && (wb_addr != 5'd0);
    assign rs1_val = (wb_live && (wb_addr == rs1_idx)) ? wb_data : rf_rd1;
    assign rs2_val = (wb_live && (wb_addr == rs2_idx)) ? wb_data : rf_rd2;

    always_comb begin
        dec        = '0;
        dec.rd     = in_instr[11:7];
        legal      = 1'b0;
        case (in_instr[6:0])
            OPC_OP: begin
                legal      = (f7 == F7_BASE) ||
                             ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                dec.funct3 = f3;
                dec.funct7 = in_instr[30];
                dec.rs1    = rs1_val;
                // The ALU shifts by its whole operand, so trim to a 5-bit amount.
                dec.rs2    = ((f3 == F3_SLL) || (f3 == F3_SR)) ?
                             {27'd0, rs2_val[4:0]} : rs2_val;
            end
            OPC_OP_IMM: begin
                dec.funct3 = f3;
                dec.rs1    = rs1_val;
                case (f3)
                    F3_SLL: begin
                        legal   = (f7 == F7_BASE);
                        dec.rs2 = {27'd0, in_instr[24:20]};
                    end
                    F3_SR: begin
                        legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
                        dec.funct7 = (f7 == F7_ALT);
                        dec.rs2    = {27'd0, in_instr[24:20]};
                    end
                    default: begin
                        legal   = 1'b1;
                        dec.rs2 = imm;
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec.rd      = in_instr[11:7];
        end
    end

    assign in_ready = (state_q == SLOT_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (accept) begin
            state_d = SLOT_FULL;
            slot_d  = dec;
        end else if ((state_q == SLOT_FULL) && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    assign out_valid   = (state_q == SLOT_FULL);
    assign out_illegal = slot_q.illegal;
    assign out_funct3  = slot_q.funct3;
    assign out_funct7  = slot_q.funct7;
    assign out_rs1     = slot_q.rs1;
    assign out_rs2     = slot_q.rs2;
    assign out_rd      = slot_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a scoreboard
// that compares every consumed output slot against a queue of expected slots.
module tb_decode_stage;

    localparam int W = 74;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_funct3;
    logic        out_funct7;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;

    assign obs = {out_illegal, out_funct3, out_funct7, out_rs1, out_rs2, out_rd};

    decode_stage #(.XLEN(32), .REG_RESET(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic ill, input logic [2:0] f3,
                                        input logic f7, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] rd);
        return {ill, f3, f7, a, b, rd};
    endfunction

    // Scoreboard: every slot consumed by the ALU side must match the oldest
    // expected entry.
    task automatic sb_monitor();
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got %h, expected no output", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        fails++;
                        $display("FAIL sb_slot: got %h, expected %h", obs, e);
                    end
                end
            end
        end
    endtask

    // driver tasks (all drives happen just after a rising edge)
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] instr, input logic [W-1:0] e);
        int n;
        bit ok;
        in_valid = 1'b1;
        in_instr = instr;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b, expected 0", out_valid);
        end
        tests++;
        if (obs !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h, expected 0", obs);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        send(32'hFFB00093, mk(1'b0, 3'b000, 1'b0, 32'h0, 32'hFFFFFFFB, 5'd1));
        tests++;
        if (out_valid !== 1'b1) begin
            fails++; $display("FAIL addi_latency: out_valid=%b, expected 1", out_valid);
        end
        idle(2);
    endtask

    task automatic test_alu_ops();
        out_ready = 1'b1;
        wb(5'd2, 32'h10);
        wb(5'd3, 32'h3);
        wb(5'd8, 32'hFFFFFF25);
        send(32'h40310233, mk(1'b0, 3'b000, 1'b1, 32'h10, 32'h3, 5'd4));        // SUB
        send(32'h40415293, mk(1'b0, 3'b101, 1'b1, 32'h10, 32'h4, 5'd5));        // SRAI
        send(32'h02415293, mk(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 5'd5));         // bad SRAI
        send(32'h01F19493, mk(1'b0, 3'b001, 1'b0, 32'h3, 32'd31, 5'd9));        // SLLI 31
        send(32'h40312533, mk(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 5'd10));        // SLT alt
        send(32'h40010593, mk(1'b0, 3'b000, 1'b0, 32'h10, 32'h400, 5'd11));     // ADDI b30
        send(32'h00811633, mk(1'b0, 3'b001, 1'b0, 32'h10, 32'h5, 5'd12));       // SLL
        send(32'h123450B7, mk(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 5'd1));         // LUI
        idle(2);
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
        send(32'h00038333, mk(1'b0, 3'b000, 1'b0, 32'hDEADBEEF, 32'h0, 5'd6));
        wb_addr = 5'd0; wb_data = 32'd5;
        send(32'h000006B3, mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd13));
        wb_en = 1'b0;
        send(32'h00738733, mk(1'b0, 3'b000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 5'd14));
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ea, eb;
        ea = mk(1'b0, 3'b000, 1'b1, 32'h10, 32'h3, 5'd4);
        eb = mk(1'b0, 3'b000, 1'b0, 32'h10, 32'h3, 5'd20);
        out_ready = 1'b0;
        send(32'h40310233, ea);
        in_valid = 1'b1;
        in_instr = 32'h00310A33;   // ADD x20,x2,x3
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_in_ready[%0d]: got %b, expected 0", i, in_ready);
            end
            tests++;
            if (out_valid !== 1'b1 || obs !== ea) begin
                fails++; $display("FAIL bp_hold[%0d]: valid=%b slot=%h, expected 1 %h", i, out_valid, obs, ea);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release: in_ready=%b, expected 1", in_ready);
        end
        exp_q.push_back(eb);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || obs !== eb) begin
            fails++; $display("FAIL bp_no_bubble: valid=%b slot=%h, expected 1 %h", out_valid, obs, eb);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        wb(5'd15, 32'h77);
        send(32'h00078833, mk(1'b0, 3'b000, 1'b0, 32'h77, 32'h0, 5'd16));
        rst = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd17; wb_data = 32'h99;
        @(posedge clk); #1;
        rst = 1'b0; wb_en = 1'b0;
        void'(exp_q.pop_back());   // slot dropped by reset
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL rstmid_valid: got %b, expected 0", out_valid);
        end
        tests++;
        if (obs !== '0) begin
            fails++; $display("FAIL rstmid_outputs: got %h, expected 0", obs);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00078933, mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd18));        // x15 cleared
        send(32'h00088A33, mk(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd20));        // x17 not written
        idle(2);
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_addi();
        test_alu_ops();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
